// File: rtl/gradient_axis_source.sv
// Raster-scans a WIDTH x HEIGHT frame, registers gradient pixels onto an AXI4-Stream master, counts clipped beats.
// Latency: start -> RUN next cycle -> first tvalid the cycle after; one beat per cycle with tready high.
// Backpressure: single output register, no skid; while tvalid && !tready the counters and beat hold.
module gradient_axis_source #(
    parameter int WIDTH      = 400,
    parameter int HEIGHT     = 200,
    parameter int CONTINUOUS = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    input  logic [31:0]               pixel_in,
    input  logic                      clipping_in,
    output logic [31:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               clip_count
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [31:0]     r_tdata;
    logic            r_tvalid;
    logic            r_tlast;
    logic            r_tuser;
    logic            r_busy;
    logic            r_done;
    logic [15:0]     r_clip_count;

    logic            w_load;
    logic            w_x_last;
    logic            w_y_last;
    logic            w_first;

    // The output register may take a new beat when it is empty or being drained this cycle.
    always_comb begin
        w_load   = (r_state == S_RUN) && (!r_tvalid || m_axis_tready);
        w_x_last = (r_x == XW'(WIDTH - 1));
        w_y_last = (r_y == YW'(HEIGHT - 1));
        w_first  = (r_x == '0) && (r_y == '0);
    end

    // Scan FSM, raster counters and AXI-Stream output register in one sequential block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tuser      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_clip_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // busy also covers the done cycle, so it only drops here.
                    r_busy <= start;
                    if (start) begin
                        r_state      <= S_RUN;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_clip_count <= '0;
                    end
                end
                S_RUN: begin
                    if (w_load) begin
                        r_tdata  <= pixel_in;
                        r_tvalid <= 1'b1;
                        r_tuser  <= w_first;
                        r_tlast  <= w_x_last;
                        if (clipping_in && (r_clip_count != 16'hFFFF)) begin
                            r_clip_count <= r_clip_count + 16'd1;
                        end
                        if (w_x_last) begin
                            r_x <= '0;
                            if (w_y_last) begin
                                r_y     <= '0;
                                r_state <= S_DRAIN;
                            end else begin
                                r_y <= r_y + YW'(1);
                            end
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Wait for the final beat to leave before reporting the frame complete.
                    if (r_tvalid && m_axis_tready) begin
                        r_tvalid <= 1'b0;
                        r_done   <= 1'b1;
                        if (CONTINUOUS != 0) begin
                            r_state      <= S_RUN;
                            r_clip_count <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign x             = r_x;
    assign y             = r_y;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign busy          = r_busy;
    assign done          = r_done;
    assign clip_count    = r_clip_count;

endmodule

// File: tb/tb_gradient_axis_source.sv
// Directed bench: small single-shot frame, small continuous frame, and a 256x256 frame for saturation.
// Latency: checks exact beat and done cycles against start.
// Backpressure: stalls tready on fixed and random cycles and checks beat hold.
module tb_gradient_axis_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: 4x2, single frame ----------------
    logic        rst_a, start_a, clip_a, tready_a;
    logic [1:0]  x_a;
    logic [0:0]  y_a;
    logic [31:0] pix_a, tdata_a;
    logic        tvalid_a, tlast_a, tuser_a, busy_a, done_a;
    logic [15:0] cc_a;
    assign pix_a = {8'h10 + {6'b0, x_a}, 8'h20 + {7'b0, y_a}, 16'h0};

    gradient_axis_source #(.WIDTH(4), .HEIGHT(2), .CONTINUOUS(0)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .x(x_a), .y(y_a),
        .pixel_in(pix_a), .clipping_in(clip_a),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
        .m_axis_tlast(tlast_a), .m_axis_tuser(tuser_a),
        .busy(busy_a), .done(done_a), .clip_count(cc_a)
    );

    // ---------------- instance B: 4x2, continuous ----------------
    logic        rst_b, start_b;
    logic [1:0]  x_b;
    logic [0:0]  y_b;
    logic [31:0] tdata_b;
    logic        tvalid_b, tlast_b, tuser_b, busy_b, done_b;
    logic [15:0] cc_b;

    gradient_axis_source #(.WIDTH(4), .HEIGHT(2), .CONTINUOUS(1)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .x(x_b), .y(y_b),
        .pixel_in(32'h0), .clipping_in(1'b1),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(1'b1),
        .m_axis_tlast(tlast_b), .m_axis_tuser(tuser_b),
        .busy(busy_b), .done(done_b), .clip_count(cc_b)
    );

    // ---------------- instance C: 256x256, saturation ----------------
    logic        rst_c, start_c;
    logic [7:0]  x_c, y_c;
    logic [31:0] tdata_c;
    logic        tvalid_c, tlast_c, tuser_c, busy_c, done_c;
    logic [15:0] cc_c;

    gradient_axis_source #(.WIDTH(256), .HEIGHT(256), .CONTINUOUS(0)) u_c (
        .clk(clk), .rst(rst_c), .start(start_c), .x(x_c), .y(y_c),
        .pixel_in(32'h0), .clipping_in(1'b1),
        .m_axis_tdata(tdata_c), .m_axis_tvalid(tvalid_c), .m_axis_tready(1'b1),
        .m_axis_tlast(tlast_c), .m_axis_tuser(tuser_c),
        .busy(busy_c), .done(done_c), .clip_count(cc_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame on A starting now (cycle 0). tready low on cycles lo..hi, or random.
    task automatic run_a(input int lo, input int hi, input bit rnd, input bit clip,
                         input int restart_cyc, input logic [15:0] exp_clip, input int exp_done);
        int k;
        int dones;
        int dcyc;
        int nk;
        k = 0; dones = 0; dcyc = 0;
        start_a  = 1'b1;
        clip_a   = clip;
        tready_a = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            step();
            start_a  = (c == restart_cyc);
            tready_a = rnd ? 1'($urandom_range(0, 1)) : !(c >= lo && c <= hi);
            if (c == 1) begin
                chk("first_cycle_tvalid", {31'b0, tvalid_a}, 32'd0);
                chk("first_cycle_busy", {31'b0, busy_a}, 32'd1);
            end
            if (c == 2) chk("first_beat_tvalid", {31'b0, tvalid_a}, 32'd1);
            if (tvalid_a) begin
                nk = (k + 1) % 8;
                chk("beat_tdata", tdata_a, {8'h10 + 8'(k % 4), 8'h20 + 8'(k / 4), 16'h0});
                chk("beat_tuser", {31'b0, tuser_a}, {31'b0, k == 0});
                chk("beat_tlast", {31'b0, tlast_a}, {31'b0, (k % 4) == 3});
                chk("counter_x", {30'b0, x_a}, 32'(nk % 4));
                chk("counter_y", {31'b0, y_a}, 32'(nk / 4));
                if (tready_a) k++;
            end
            if (done_a) begin
                dones++;
                dcyc = c;
                chk("done_clip_count", {16'b0, cc_a}, {16'b0, exp_clip});
                chk("done_beats", 32'(k), 32'd8);
            end
            if (dcyc == 0) begin
                chk("busy_during_frame", {31'b0, busy_a}, 32'd1);
            end else if (c > dcyc) begin
                chk("busy_after_done", {31'b0, busy_a}, 32'd0);
                chk("tvalid_after_done", {31'b0, tvalid_a}, 32'd0);
            end
        end
        tready_a = 1'b1;
        clip_a   = 1'b0;
        chk("frame_beats", 32'(k), 32'd8);
        chk("frame_dones", 32'(dones), 32'd1);
        if (exp_done != 0) chk("done_cycle", 32'(dcyc), 32'(exp_done));
    endtask

    initial begin
        int kb, tu_b, db;
        logic [15:0] prev_cc;
        int beats_c, tlasts_c, tusers_c;
        bit seen_c;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        clip_a = 1'b0; tready_a = 1'b1;
        step(); step();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        step();

        // Reset state
        chk("rst_tvalid", {31'b0, tvalid_a}, 32'd0);
        chk("rst_tdata", tdata_a, 32'd0);
        chk("rst_tlast", {31'b0, tlast_a}, 32'd0);
        chk("rst_tuser", {31'b0, tuser_a}, 32'd0);
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        chk("rst_done", {31'b0, done_a}, 32'd0);
        chk("rst_clip", {16'b0, cc_a}, 32'd0);
        chk("rst_xy", {29'b0, x_a, y_a}, 32'd0);
        chk("rst_b_busy", {31'b0, busy_b}, 32'd0);

        // T1: free-flowing frame, beats on cycles 2..9, done on 10
        run_a(-1, -1, 1'b0, 1'b0, 0, 16'd0, 10);
        // T2: stall on cycles 3..5 holds beat 1 and counters, done slips by 3
        run_a(3, 5, 1'b0, 1'b0, 0, 16'd0, 13);
        // T4: every beat clipped
        run_a(-1, -1, 1'b0, 1'b1, 0, 16'd8, 10);
        // T6: start during RUN is ignored
        run_a(-1, -1, 1'b0, 1'b0, 4, 16'd0, 10);
        // Random backpressure
        run_a(-1, -1, 1'b1, 1'b1, 0, 16'd8, 0);

        // T5: reset while beat 3 is on the bus
        start_a = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            start_a = 1'b0;
        end
        chk("pre_rst_tvalid", {31'b0, tvalid_a}, 32'd1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("post_rst_tvalid", {31'b0, tvalid_a}, 32'd0);
        chk("post_rst_busy", {31'b0, busy_a}, 32'd0);
        chk("post_rst_xy", {29'b0, x_a, y_a}, 32'd0);
        for (int c = 0; c < 12; c++) begin
            chk("post_rst_no_done", {31'b0, done_a}, 32'd0);
            step();
        end
        run_a(-1, -1, 1'b0, 1'b0, 0, 16'd0, 10);

        // T6: continuous frames back to back, one idle cycle between
        kb = 0; tu_b = 0; db = 0; prev_cc = 16'd0;
        start_b = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            step();
            start_b = 1'b0;
            if (tvalid_b) begin
                if (tuser_b) begin
                    tu_b++;
                    chk("cont_tuser_beat", 32'(kb % 8), 32'd0);
                end
                chk("cont_tlast", {31'b0, tlast_b}, {31'b0, (kb % 4) == 3});
                kb++;
            end
            if (done_b) begin
                db++;
                chk("cont_done_cycle", 32'(c), 32'(10 + 9 * (db - 1)));
                chk("cont_clip_before_done", {16'b0, prev_cc}, 32'd8);
                chk("cont_clip_cleared", {16'b0, cc_b}, 32'd0);
                chk("cont_busy", {31'b0, busy_b}, 32'd1);
            end
            prev_cc = cc_b;
        end
        chk("cont_beats", 32'(kb), 32'd24);
        chk("cont_tusers", 32'(tu_b), 32'd3);
        chk("cont_dones", 32'(db), 32'd3);

        // Saturation: 65536 clipped beats must stop at FFFF
        beats_c = 0; tlasts_c = 0; tusers_c = 0; seen_c = 1'b0;
        start_c = 1'b1;
        for (int c = 1; c <= 70000; c++) begin
            step();
            start_c = 1'b0;
            if (tvalid_c) begin
                beats_c++;
                if (tlast_c) tlasts_c++;
                if (tuser_c) tusers_c++;
            end
            if (done_c) begin
                seen_c = 1'b1;
                break;
            end
        end
        chk("sat_done_seen", {31'b0, seen_c}, 32'd1);
        chk("sat_clip_count", {16'b0, cc_c}, 32'h0000FFFF);
        chk("sat_beats", 32'(beats_c), 32'd65536);
        chk("sat_tlasts", 32'(tlasts_c), 32'd256);
        chk("sat_tusers", 32'(tusers_c), 32'd1);
        chk("sat_xy_home", {16'b0, x_c, y_c}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
